// File: rtl/pram_boot_sequencer_pkg.sv
// Shared definitions for the PRAM boot sequencer: state encoding, memory-map
// defaults and small helpers used by the sequencer and its watchdog.
package pram_boot_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } boot_state_t;

    typedef struct packed {
        logic load;
        logic hold;
        logic done;
        logic error;
    } boot_flags_t;

    localparam logic [15:0] BOOT_SRC_BASE    = 16'h4000;
    localparam logic [15:0] BOOT_DST_BASE    = 16'h0000;
    localparam logic [15:0] PRAM_WORDS       = 16'd4096;
    localparam logic [15:0] BOOT_ADDR_STEP   = 16'd4;
    localparam logic [7:0]  BOOT_ACK_TIMEOUT = 8'd255;

    // Status outputs are a pure function of the state they are decoded from.
    function automatic boot_flags_t decode_flags(input boot_state_t st);
        boot_flags_t f;
        case (st)
            ST_IDLE:  f = '{load: 1'b0, hold: 1'b1, done: 1'b0, error: 1'b0};
            ST_LOAD:  f = '{load: 1'b1, hold: 1'b1, done: 1'b0, error: 1'b0};
            ST_DONE:  f = '{load: 1'b0, hold: 1'b0, done: 1'b1, error: 1'b0};
            ST_ERROR: f = '{load: 1'b0, hold: 1'b1, done: 1'b0, error: 1'b1};
            default:  f = '{load: 1'b0, hold: 1'b1, done: 1'b0, error: 1'b0};
        endcase
        return f;
    endfunction

    function automatic logic [15:0] step_addr(input logic [15:0] addr, input logic [15:0] step);
        return addr + step;
    endfunction

endpackage

// File: rtl/pram_boot_sequencer_if.sv
// Boot-load bus between the sequencer (master) and the memory_controller
// datapath (slave) that performs the actual word moves.
interface pram_boot_sequencer_if;
    logic        bus_ack;
    logic        load_when_reset;
    logic [15:0] addr_counter;
    logic [15:0] pram_load_addr;

    modport master (
        input  bus_ack,
        output load_when_reset,
        output addr_counter,
        output pram_load_addr
    );

    modport slave (
        output bus_ack,
        input  load_when_reset,
        input  addr_counter,
        input  pram_load_addr
    );
endinterface

// File: rtl/pram_boot_sequencer_watchdog.sv
// Bus-ack watchdog: counts consecutive enabled cycles without a clear and
// flags expiry on the cycle the count sits at ACK_TIMEOUT-1.
module pram_boot_sequencer_watchdog #(
    parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_r;

    // Idle-cycle counter; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Expiry is combinational so the owner can still let a same-cycle ack win.
    always_comb begin
        expired = 1'b0;
        if (enable && (count_r == (ACK_TIMEOUT - 8'd1))) begin
            expired = 1'b1;
        end else begin
            expired = 1'b0;
        end
    end

endmodule

// File: rtl/pram_boot_sequencer.sv
// Reset-time boot sequencer: walks source/destination addresses while the
// memory_controller copies WORD_COUNT words into PRAM, holding the core off.
module pram_boot_sequencer
    import pram_boot_sequencer_pkg::*;
#(
    parameter logic [15:0] SRC_BASE    = BOOT_SRC_BASE,
    parameter logic [15:0] DST_BASE    = BOOT_DST_BASE,
    parameter logic [15:0] WORD_COUNT  = PRAM_WORDS,
    parameter logic [15:0] ADDR_STEP   = BOOT_ADDR_STEP,
    parameter logic [7:0]  ACK_TIMEOUT = BOOT_ACK_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         boot_en,
    pram_boot_sequencer_if.master        bus,
    output logic                         core_hold,
    output logic                         boot_done,
    output logic                         boot_error,
    output logic [15:0]                  words_loaded
);

    boot_state_t state_r;
    boot_state_t next_state_s;
    boot_flags_t flags_r;
    boot_flags_t next_flags_s;

    logic [15:0] addr_r;
    logic [15:0] pram_r;
    logic [15:0] words_r;
    logic        in_load_s;
    logic        accept_s;
    logic        last_word_s;
    logic        wd_clear_s;
    logic        wd_expired_s;

    assign in_load_s   = (state_r == ST_LOAD);
    assign accept_s    = in_load_s && bus.bus_ack;
    assign last_word_s = (words_r == (WORD_COUNT - 16'd1));
    assign wd_clear_s  = (!in_load_s) || bus.bus_ack;

    pram_boot_sequencer_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear_s),
        .enable  (in_load_s),
        .expired (wd_expired_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; an ack in the timeout cycle takes precedence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (boot_en) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_LOAD: begin
                if (bus.bus_ack) begin
                    if (last_word_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_LOAD;
                    end
                end else if (wd_expired_s) begin
                    next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_DONE:  next_state_s = ST_DONE;
            ST_ERROR: next_state_s = ST_ERROR;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so flags align with state_r.
    always_comb begin
        next_flags_s = decode_flags(next_state_s);
    end

    // Registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= decode_flags(ST_IDLE);
        end else begin
            flags_r <= next_flags_s;
        end
    end

    // Address and word counters advance only on an ack accepted in LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r  <= SRC_BASE;
            pram_r  <= DST_BASE;
            words_r <= 16'd0;
        end else if (accept_s) begin
            addr_r  <= step_addr(addr_r, ADDR_STEP);
            pram_r  <= step_addr(pram_r, ADDR_STEP);
            words_r <= words_r + 16'd1;
        end else begin
            addr_r  <= addr_r;
            pram_r  <= pram_r;
            words_r <= words_r;
        end
    end

    assign bus.load_when_reset = flags_r.load;
    assign bus.addr_counter    = addr_r;
    assign bus.pram_load_addr  = pram_r;
    assign core_hold           = flags_r.hold;
    assign boot_done           = flags_r.done;
    assign boot_error          = flags_r.error;
    assign words_loaded        = words_r;

endmodule

// File: tb/tb_pram_boot_sequencer.sv
// Directed bench: table-driven 4-word boot plus hand sequences on a full-size instance.
module tb_pram_boot_sequencer;

    logic clk;
    logic rst, en, hold, done, err;
    logic rst4, en4, hold4, done4, err4;
    logic [15:0] words, words4;

    int checks   = 0;
    int failures = 0;

    pram_boot_sequencer_if bif ();
    pram_boot_sequencer_if bif4 ();

    pram_boot_sequencer dut (
        .clk          (clk),
        .reset        (rst),
        .boot_en      (en),
        .bus          (bif.master),
        .core_hold    (hold),
        .boot_done    (done),
        .boot_error   (err),
        .words_loaded (words)
    );

    pram_boot_sequencer #(.WORD_COUNT(16'd4)) dut4 (
        .clk          (clk),
        .reset        (rst4),
        .boot_en      (en4),
        .bus          (bif4.master),
        .core_hold    (hold4),
        .boot_done    (done4),
        .boot_error   (err4),
        .words_loaded (words4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {lwr, addr, pram, hold, done, err, words} = 52 bits.
    typedef struct {
        logic        rst;
        logic        en;
        logic        ack;
        logic [51:0] exp;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [51:0] pk(input logic lwr, input logic [15:0] a, input logic [15:0] p,
                                      input logic h, input logic d, input logic e, input logic [15:0] w);
        return {lwr, a, p, h, d, e, w};
    endfunction

    function automatic logic [51:0] obs();
        return {bif.load_when_reset, bif.addr_counter, bif.pram_load_addr, hold, done, err, words};
    endfunction

    function automatic logic [51:0] obs4();
        return {bif4.load_when_reset, bif4.addr_counter, bif4.pram_load_addr, hold4, done4, err4, words4};
    endfunction

    task automatic chk(input string name, input logic [51:0] act, input logic [51:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic boot);
        rst = 1'b1; en = boot; bif.bus_ack = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; bif.bus_ack = 1'b0;
        rst4 = 1'b1; en4 = 1'b1; bif4.bus_ack = 1'b0;

        // 4-word boot, ack every third LOAD cycle, then ack pulses in DONE.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, pk(1'b0, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0)};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, pk(1'b1, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0)};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, pk(1'b1, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0)};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, pk(1'b1, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0)};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, pk(1'b1, 16'h4004, 16'h0004, 1'b1, 1'b0, 1'b0, 16'd1)};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, pk(1'b1, 16'h4004, 16'h0004, 1'b1, 1'b0, 1'b0, 16'd1)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, pk(1'b1, 16'h4004, 16'h0004, 1'b1, 1'b0, 1'b0, 16'd1)};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, pk(1'b1, 16'h4008, 16'h0008, 1'b1, 1'b0, 1'b0, 16'd2)};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, pk(1'b1, 16'h4008, 16'h0008, 1'b1, 1'b0, 1'b0, 16'd2)};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, pk(1'b1, 16'h4008, 16'h0008, 1'b1, 1'b0, 1'b0, 16'd2)};
        tbl[10] = '{1'b0, 1'b0, 1'b1, pk(1'b1, 16'h400C, 16'h000C, 1'b1, 1'b0, 1'b0, 16'd3)};
        tbl[11] = '{1'b0, 1'b0, 1'b0, pk(1'b1, 16'h400C, 16'h000C, 1'b1, 1'b0, 1'b0, 16'd3)};
        tbl[12] = '{1'b0, 1'b0, 1'b0, pk(1'b1, 16'h400C, 16'h000C, 1'b1, 1'b0, 1'b0, 16'd3)};
        tbl[13] = '{1'b0, 1'b0, 1'b1, pk(1'b0, 16'h4010, 16'h0010, 1'b0, 1'b1, 1'b0, 16'd4)};
        tbl[14] = '{1'b0, 1'b0, 1'b1, pk(1'b0, 16'h4010, 16'h0010, 1'b0, 1'b1, 1'b0, 16'd4)};
        tbl[15] = '{1'b0, 1'b1, 1'b0, pk(1'b0, 16'h4010, 16'h0010, 1'b0, 1'b1, 1'b0, 16'd4)};

        for (int i = 0; i < 16; i++) begin
            rst4 = tbl[i].rst; en4 = tbl[i].en; bif4.bus_ack = tbl[i].ack;
            tick();
            chk($sformatf("vec%0d", i), obs4(), tbl[i].exp);
        end

        // boot_en=0: DONE one cycle after release, ack in IDLE/DONE ignored.
        rst = 1'b1; en = 1'b0; bif.bus_ack = 1'b0;
        tick();
        chk("skip_reset", obs(), pk(1'b0, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0));
        rst = 1'b0; bif.bus_ack = 1'b1;
        tick();
        chk("skip_done", obs(), pk(1'b0, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd0));
        for (int i = 0; i < 4; i++) begin
            bif.bus_ack = i[0]; en = 1'b1;
            tick();
            chk($sformatf("skip_hold%0d", i), obs(), pk(1'b0, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd0));
        end

        // Reset after three acks aborts and restarts from the base addresses.
        do_reset(1'b1);
        tick();
        bif.bus_ack = 1'b1;
        repeat (3) tick();
        chk("abort_pre", obs(), pk(1'b1, 16'h400C, 16'h000C, 1'b1, 1'b0, 1'b0, 16'd3));
        rst = 1'b1;
        tick();
        chk("abort_reset", obs(), pk(1'b0, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0));
        rst = 1'b0;
        tick();
        chk("abort_idle_ack", obs(), pk(1'b1, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0));
        tick();
        chk("abort_restart", obs(), pk(1'b1, 16'h4004, 16'h0004, 1'b1, 1'b0, 1'b0, 16'd1));

        // Timeout after two words; boot_en change mid-LOAD has no effect.
        do_reset(1'b1);
        tick();
        bif.bus_ack = 1'b1;
        repeat (2) tick();
        bif.bus_ack = 1'b0; en = 1'b0;
        repeat (254) tick();
        chk("to_pre", obs(), pk(1'b1, 16'h4008, 16'h0008, 1'b1, 1'b0, 1'b0, 16'd2));
        tick();
        chk("to_error", obs(), pk(1'b0, 16'h4008, 16'h0008, 1'b1, 1'b0, 1'b1, 16'd2));
        bif.bus_ack = 1'b1;
        repeat (3) tick();
        chk("to_frozen", obs(), pk(1'b0, 16'h4008, 16'h0008, 1'b1, 1'b0, 1'b1, 16'd2));

        // Ack in the timeout cycle wins and restarts the watchdog.
        do_reset(1'b1);
        tick();
        repeat (254) tick();
        bif.bus_ack = 1'b1;
        tick();
        chk("edge_ack", obs(), pk(1'b1, 16'h4004, 16'h0004, 1'b1, 1'b0, 1'b0, 16'd1));
        bif.bus_ack = 1'b0;
        repeat (254) tick();
        chk("edge_pre", obs(), pk(1'b1, 16'h4004, 16'h0004, 1'b1, 1'b0, 1'b0, 16'd1));
        tick();
        chk("edge_error", obs(), pk(1'b0, 16'h4004, 16'h0004, 1'b1, 1'b0, 1'b1, 16'd1));

        // Full 4096-word copy with ack every cycle.
        do_reset(1'b1);
        bif.bus_ack = 1'b1;
        tick();
        chk("full_start", obs(), pk(1'b1, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0));
        repeat (4095) tick();
        chk("full_penult", obs(), pk(1'b1, 16'h7FFC, 16'h3FFC, 1'b1, 1'b0, 1'b0, 16'd4095));
        tick();
        chk("full_done", obs(), pk(1'b0, 16'h8000, 16'h4000, 1'b0, 1'b1, 1'b0, 16'd4096));
        tick();
        chk("full_stay", obs(), pk(1'b0, 16'h8000, 16'h4000, 1'b0, 1'b1, 1'b0, 16'd4096));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
